cache_miss_sequencer: RTL and testbench
=======================================

Name: cache_miss_sequencer

Overview:
- Control FSM for one cache: accepts a CPU read/write, sequences tag lookup, hit access, dirty-victim write-back, block fetch and line refill.
- Sits between the CPU request signals, the tag/data arrays, and the main-memory fetch/write-back path of the controller interface.
- Drives strobes, way select and memory handshakes only; it carries no data.

Parameters:
NUM_WAYS, 4, associativity; WAY_W = $clog2(NUM_WAYS)
BLOCK_SIZE, 32, line size in bytes; OFFSET_W = $clog2(BLOCK_SIZE)
ADDRESS_WIDTH, 32, address width
COUNTER_WIDTH, 8, memory-wait counter width; timeout at 2**COUNTER_WIDTH-1 cycles

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
cpuRequest  in  1  request valid; sampled in IDLE only
cpuRead  in  1  read op
cpuWrite  in  1  write op
cpuRequestAddress  in  ADDRESS_WIDTH  request address
cpuReady  out  1  high only in IDLE
cpuDone  out  1  one-cycle completion pulse
cpuError  out  1  one-cycle error pulse (illegal op or memory timeout)
lookupEn  out  1  tag lookup strobe
lookupHit  in  1  hit, valid in the lookupEn cycle (combinational tag array)
lookupWay  in  WAY_W  hit way
victimWay  in  WAY_W  replacement choice, valid with lookupEn
victimDirty  in  1  victim line valid and dirty
victimAddress  in  ADDRESS_WIDTH  victim block base address
wayIndex  out  WAY_W  way for data/fill/status strobes
dataReadEn  out  1  read word to dataToRegister
dataWriteEn  out  1  write dataFromRegister word
lineDirtySet  out  1  set dirty bit of wayIndex
fillEn  out  1  load fetchedData into wayIndex and set valid, clear dirty
memFetchReq  out  1  fetch request, level
fetchAddress  out  ADDRESS_WIDTH  block base, offset bits zero
memFetchAck  in  1  fetchedData valid this cycle
memWriteBackReq  out  1  write-back request, level
writeBackAddress  out  ADDRESS_WIDTH  equals latched victimAddress
memWriteBackAck  in  1  writeBackData accepted

Behaviour:
- Reset: state IDLE; cpuReady=1; every other output 0; latches and counter 0. Reset mid-operation aborts immediately and drops memory requests asynchronously; no cpuDone.
- States: IDLE, LOOKUP, ACCESS, RESPOND, WRITEBACK, FETCH, REFILL.
- IDLE: cpuRequest with exactly one of cpuRead/cpuWrite latches address and op, then goes to LOOKUP. cpuRequest with both or neither: cpuError pulses next cycle and the FSM stays IDLE.
- LOOKUP (1 cycle, lookupEn=1):
  - hit: latch way=lookupWay, go to ACCESS.
  - miss: latch way=victimWay and writeBackAddress=victimAddress; victimDirty goes to WRITEBACK, otherwise FETCH.
- ACCESS (1 cycle): wayIndex=way; read asserts dataReadEn; write asserts dataWriteEn and lineDirtySet. Next state RESPOND.
- RESPOND: cpuDone=1 for one cycle, then IDLE.
- WRITEBACK: memWriteBackReq held until memWriteBackAck, then FETCH with the counter cleared.
- FETCH: memFetchReq held, fetchAddress = {addr[AW-1:OFFSET_W], OFFSET_W'b0}, until memFetchAck, then REFILL.
- REFILL (1 cycle): fillEn=1, wayIndex=way, then ACCESS. A write miss is therefore fill-then-write, with the dirty bit set in ACCESS.
- Wait counter: cleared on entering WRITEBACK/FETCH, +1 per waiting cycle, saturating. At 2**COUNTER_WIDTH-1 without ack: cpuError pulse, request dropped, go to IDLE, line untouched. Ack in the timeout cycle wins over the timeout.
- Hit latency: request sampled at cycle 0, cpuDone at cycle 3. Clean miss: 5 + fetch wait cycles.
- cpuRequest outside IDLE is ignored; the CPU holds it until cpuReady.
- Each of memFetchReq and memWriteBackReq is a registered output; never both high.

Decomposition:
- Package cache_pkg holds state_t enum, op_t {OP_READ, OP_WRITE}, and OFFSET_W/WAY_W helper functions of the parameters.
- Optional sub-module mem_wait_timer (counter, clear, enable, timeout flag), reusable by the memory-side model.
- Everything else stays in one FSM module.

Test Plan:
- Read hit: lookupHit=1, lookupWay=2, request at cycle 0 -> dataReadEn with wayIndex=2 at cycle 2, cpuDone at cycle 3, no memory requests.
- Write miss, clean victim: victimWay=1, victimDirty=0, addr 0x0000_1234 -> fetchAddress 0x0000_1220; ack after 4 cycles -> fillEn, then dataWriteEn+lineDirtySet on way 1, cpuDone.
- Read miss, dirty victim: victimAddress 0x0000_8000 -> memWriteBackReq with writeBackAddress 0x0000_8000 until ack, then FETCH, REFILL, ACCESS, cpuDone; req lines never overlap.
- Fetch timeout (COUNTER_WIDTH=4): never ack -> cpuError at wait cycle 15, memFetchReq low, cpuReady=1, no fillEn.
- Illegal op: cpuRead=cpuWrite=1 -> cpuError one cycle, state stays IDLE, lookupEn never asserted.
- Reset mid-FETCH: rst_n low -> memFetchReq low immediately; after release cpuReady=1; a new hit request completes in 3 cycles.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared types and width helpers for the cache miss sequencer.
package cache_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LOOKUP    = 3'd1,
    ST_ACCESS    = 3'd2,
    ST_RESPOND   = 3'd3,
    ST_WRITEBACK = 3'd4,
    ST_FETCH     = 3'd5,
    ST_REFILL    = 3'd6
  } state_t;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } op_t;

  function automatic int offset_w(input int block_size);
    return $clog2(block_size);
  endfunction

  // A direct-mapped cache still needs a one-bit way field.
  function automatic int way_w(input int num_ways);
    return (num_ways > 1) ? $clog2(num_ways) : 1;
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Saturating wait counter for memory handshakes; flags timeout at all-ones.
module mem_wait_timer #(
  parameter int COUNTER_WIDTH = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_timeout
);

  localparam logic [COUNTER_WIDTH-1:0] CNT_MAX  = {COUNTER_WIDTH{1'b1}};
  localparam logic [COUNTER_WIDTH-1:0] CNT_ONE  = {{(COUNTER_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [COUNTER_WIDTH-1:0] CNT_ZERO = {COUNTER_WIDTH{1'b0}};

  logic [COUNTER_WIDTH-1:0] r_count;

  // Clear wins over counting; the count holds once it reaches the maximum.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= CNT_ZERO;
    end else if (i_clear) begin
      r_count <= CNT_ZERO;
    end else if (i_enable && (r_count != CNT_MAX)) begin
      r_count <= r_count + CNT_ONE;
    end else begin
      r_count <= r_count;
    end
  end

  assign o_timeout = (r_count == CNT_MAX);

endmodule

// File: rtl/cache_miss_sequencer.sv
// Cache control FSM: lookup, hit access, dirty write-back, block fetch and refill.
// Outputs are registered from the next-state decode so each lines up with its state.
module cache_miss_sequencer
  import cache_pkg::*;
#(
  parameter  int NUM_WAYS      = 4,
  parameter  int BLOCK_SIZE    = 32,
  parameter  int ADDRESS_WIDTH = 32,
  parameter  int COUNTER_WIDTH = 8,
  localparam int WAY_W         = way_w(NUM_WAYS),
  localparam int OFFSET_W      = offset_w(BLOCK_SIZE)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cpuRequest,
  input  logic                     cpuRead,
  input  logic                     cpuWrite,
  input  logic [ADDRESS_WIDTH-1:0] cpuRequestAddress,
  output logic                     cpuReady,
  output logic                     cpuDone,
  output logic                     cpuError,
  output logic                     lookupEn,
  input  logic                     lookupHit,
  input  logic [WAY_W-1:0]         lookupWay,
  input  logic [WAY_W-1:0]         victimWay,
  input  logic                     victimDirty,
  input  logic [ADDRESS_WIDTH-1:0] victimAddress,
  output logic [WAY_W-1:0]         wayIndex,
  output logic                     dataReadEn,
  output logic                     dataWriteEn,
  output logic                     lineDirtySet,
  output logic                     fillEn,
  output logic                     memFetchReq,
  output logic [ADDRESS_WIDTH-1:0] fetchAddress,
  input  logic                     memFetchAck,
  output logic                     memWriteBackReq,
  output logic [ADDRESS_WIDTH-1:0] writeBackAddress,
  input  logic                     memWriteBackAck
);

  localparam logic [ADDRESS_WIDTH-1:0] OFFSET_MASK =
    {{(ADDRESS_WIDTH-OFFSET_W){1'b0}}, {OFFSET_W{1'b1}}};
  localparam logic [ADDRESS_WIDTH-1:0] ADDR_ZERO = {ADDRESS_WIDTH{1'b0}};
  localparam logic [WAY_W-1:0]         WAY_ZERO  = {WAY_W{1'b0}};

  state_t                   r_state;
  state_t                   w_state_next;
  op_t                      r_op;
  op_t                      w_op_next;
  logic [ADDRESS_WIDTH-1:0] r_addr;
  logic [ADDRESS_WIDTH-1:0] w_addr_next;
  logic [ADDRESS_WIDTH-1:0] r_wb_addr;
  logic [ADDRESS_WIDTH-1:0] w_wb_addr_next;
  logic [WAY_W-1:0]         r_way;
  logic [WAY_W-1:0]         w_way_next;
  logic                     w_error_next;
  logic                     w_timer_clear;
  logic                     w_timer_enable;
  logic                     w_timeout;
  logic                     w_access_read;
  logic                     w_access_write;

  // Next-state and latch update logic.
  always_comb begin
    w_state_next   = r_state;
    w_op_next      = r_op;
    w_addr_next    = r_addr;
    w_wb_addr_next = r_wb_addr;
    w_way_next     = r_way;
    w_error_next   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (cpuRequest && (cpuRead ^ cpuWrite)) begin
          w_state_next = ST_LOOKUP;
          w_op_next    = cpuWrite ? OP_WRITE : OP_READ;
          w_addr_next  = cpuRequestAddress;
        end else if (cpuRequest) begin
          w_error_next = 1'b1;
        end else begin
          w_state_next = ST_IDLE;
        end
      end
      ST_LOOKUP: begin
        if (lookupHit) begin
          w_way_next   = lookupWay;
          w_state_next = ST_ACCESS;
        end else begin
          w_way_next     = victimWay;
          w_wb_addr_next = victimAddress;
          w_state_next   = victimDirty ? ST_WRITEBACK : ST_FETCH;
        end
      end
      ST_ACCESS:  w_state_next = ST_RESPOND;
      ST_RESPOND: w_state_next = ST_IDLE;
      ST_WRITEBACK: begin
        if (memWriteBackAck) begin
          w_state_next = ST_FETCH;
        end else if (w_timeout) begin
          w_state_next = ST_IDLE;
          w_error_next = 1'b1;
        end else begin
          w_state_next = ST_WRITEBACK;
        end
      end
      ST_FETCH: begin
        // An ack arriving in the timeout cycle still completes the fetch.
        if (memFetchAck) begin
          w_state_next = ST_REFILL;
        end else if (w_timeout) begin
          w_state_next = ST_IDLE;
          w_error_next = 1'b1;
        end else begin
          w_state_next = ST_FETCH;
        end
      end
      ST_REFILL:  w_state_next = ST_ACCESS;
      default:    w_state_next = ST_IDLE;
    endcase
  end

  assign w_timer_clear  = (w_state_next != r_state) &&
                          ((w_state_next == ST_WRITEBACK) || (w_state_next == ST_FETCH));
  assign w_timer_enable = ((r_state == ST_WRITEBACK) && !memWriteBackAck) ||
                          ((r_state == ST_FETCH) && !memFetchAck);
  assign w_access_read  = (w_state_next == ST_ACCESS) && (w_op_next == OP_READ);
  assign w_access_write = (w_state_next == ST_ACCESS) && (w_op_next == OP_WRITE);

  mem_wait_timer #(
    .COUNTER_WIDTH (COUNTER_WIDTH)
  ) u_wait_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_clear   (w_timer_clear),
    .i_enable  (w_timer_enable),
    .o_timeout (w_timeout)
  );

  // State and request latches.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_op      <= OP_READ;
      r_addr    <= ADDR_ZERO;
      r_wb_addr <= ADDR_ZERO;
      r_way     <= WAY_ZERO;
    end else begin
      r_state   <= w_state_next;
      r_op      <= w_op_next;
      r_addr    <= w_addr_next;
      r_wb_addr <= w_wb_addr_next;
      r_way     <= w_way_next;
    end
  end

  // Registered output decode; reset drops memory requests immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cpuReady         <= 1'b1;
      cpuDone          <= 1'b0;
      cpuError         <= 1'b0;
      lookupEn         <= 1'b0;
      wayIndex         <= WAY_ZERO;
      dataReadEn       <= 1'b0;
      dataWriteEn      <= 1'b0;
      lineDirtySet     <= 1'b0;
      fillEn           <= 1'b0;
      memFetchReq      <= 1'b0;
      fetchAddress     <= ADDR_ZERO;
      memWriteBackReq  <= 1'b0;
      writeBackAddress <= ADDR_ZERO;
    end else begin
      cpuReady         <= (w_state_next == ST_IDLE);
      cpuDone          <= (w_state_next == ST_RESPOND);
      cpuError         <= w_error_next;
      lookupEn         <= (w_state_next == ST_LOOKUP);
      wayIndex         <= ((w_state_next == ST_ACCESS) || (w_state_next == ST_REFILL)) ?
                          w_way_next : WAY_ZERO;
      dataReadEn       <= w_access_read;
      dataWriteEn      <= w_access_write;
      lineDirtySet     <= w_access_write;
      fillEn           <= (w_state_next == ST_REFILL);
      memFetchReq      <= (w_state_next == ST_FETCH);
      fetchAddress     <= (w_state_next == ST_FETCH) ? (w_addr_next & ~OFFSET_MASK) : ADDR_ZERO;
      memWriteBackReq  <= (w_state_next == ST_WRITEBACK);
      writeBackAddress <= w_wb_addr_next;
    end
  end

endmodule

// File: tb/tb_cache_miss_sequencer.sv
// Randomized bench: per-transaction expected output timeline built from phase lengths.
module tb_cache_miss_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cpuRequest, cpuRead, cpuWrite;
  logic [31:0] cpuRequestAddress;
  logic        cpuReady, cpuDone, cpuError, lookupEn;
  logic        lookupHit, victimDirty;
  logic [1:0]  lookupWay, victimWay, wayIndex;
  logic [31:0] victimAddress, fetchAddress, writeBackAddress;
  logic        dataReadEn, dataWriteEn, lineDirtySet, fillEn;
  logic        memFetchReq, memFetchAck, memWriteBackReq, memWriteBackAck;

  int total = 0;
  int bad   = 0;

  // Output vector: {ready,done,err,lookup,rd,wr,dirty,fill,freq,wbreq,way[1:0]}
  localparam logic [11:0] B_READY = 12'h800;
  localparam logic [11:0] B_DONE  = 12'h400;
  localparam logic [11:0] B_ERR   = 12'h200;
  localparam logic [11:0] B_LOOK  = 12'h100;
  localparam logic [11:0] B_RD    = 12'h080;
  localparam logic [11:0] B_WR    = 12'h040;
  localparam logic [11:0] B_DIRTY = 12'h020;
  localparam logic [11:0] B_FILL  = 12'h010;
  localparam logic [11:0] B_FREQ  = 12'h008;
  localparam logic [11:0] B_WBREQ = 12'h004;
  localparam int          MAX_WAIT = 15;

  cache_miss_sequencer #(
    .NUM_WAYS(4), .BLOCK_SIZE(32), .ADDRESS_WIDTH(32), .COUNTER_WIDTH(4)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cpuRequest(cpuRequest), .cpuRead(cpuRead), .cpuWrite(cpuWrite),
    .cpuRequestAddress(cpuRequestAddress),
    .cpuReady(cpuReady), .cpuDone(cpuDone), .cpuError(cpuError),
    .lookupEn(lookupEn), .lookupHit(lookupHit), .lookupWay(lookupWay),
    .victimWay(victimWay), .victimDirty(victimDirty), .victimAddress(victimAddress),
    .wayIndex(wayIndex), .dataReadEn(dataReadEn), .dataWriteEn(dataWriteEn),
    .lineDirtySet(lineDirtySet), .fillEn(fillEn),
    .memFetchReq(memFetchReq), .fetchAddress(fetchAddress), .memFetchAck(memFetchAck),
    .memWriteBackReq(memWriteBackReq), .writeBackAddress(writeBackAddress),
    .memWriteBackAck(memWriteBackAck)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [11:0] obs();
    return {cpuReady, cpuDone, cpuError, lookupEn, dataReadEn, dataWriteEn,
            lineDirtySet, fillEn, memFetchReq, memWriteBackReq, wayIndex};
  endfunction

  // One CPU transaction; wbw/fw = cycles the memory lets a request wait before acking.
  task automatic run_txn(input string name, input logic rd, input logic wr,
                         input logic [31:0] addr, input logic hit, input logic [1:0] lway,
                         input logic [1:0] vway, input logic vdirty, input logic [31:0] vaddr,
                         input int wbw, input int fw);
    logic [11:0] ev [0:63];
    bit          wa [0:63];
    bit          fa [0:63];
    bit          cwa [0:63];
    bit          cfa [0:63];
    logic [1:0]  way;
    int          t;
    int          len;
    for (int i = 0; i < 64; i++) begin
      ev[i] = 12'h000; wa[i] = 1'b0; fa[i] = 1'b0; cwa[i] = 1'b0; cfa[i] = 1'b0;
    end
    len = 0;
    way = hit ? lway : vway;
    if (rd == wr) begin
      ev[1] = B_READY | B_ERR;
      len   = 1;
    end else begin
      ev[1] = B_LOOK;
      t = 2;
      if (!hit && vdirty) begin
        for (int j = 0; j <= ((wbw > MAX_WAIT) ? MAX_WAIT : wbw); j++) begin
          ev[t+j] = B_WBREQ; cwa[t+j] = 1'b1;
        end
        if (wbw > MAX_WAIT) begin
          ev[t+MAX_WAIT+1] = B_READY | B_ERR; len = t + MAX_WAIT + 1;
        end else begin
          wa[t+wbw] = 1'b1; t = t + wbw + 1;
        end
      end
      if (len == 0 && !hit) begin
        for (int j = 0; j <= ((fw > MAX_WAIT) ? MAX_WAIT : fw); j++) begin
          ev[t+j] = B_FREQ; cfa[t+j] = 1'b1;
        end
        if (fw > MAX_WAIT) begin
          ev[t+MAX_WAIT+1] = B_READY | B_ERR; len = t + MAX_WAIT + 1;
        end else begin
          fa[t+fw] = 1'b1; t = t + fw + 1;
          ev[t] = B_FILL | {10'b0, way}; t = t + 1;
        end
      end
      if (len == 0) begin
        ev[t]   = (rd ? B_RD : (B_WR | B_DIRTY)) | {10'b0, way};
        ev[t+1] = B_DONE;
        len     = t + 1;
      end
    end

    @(negedge clk);
    check_val({name, "_idle"}, obs(), B_READY);
    cpuRequest = 1'b1; cpuRead = rd; cpuWrite = wr; cpuRequestAddress = addr;
    lookupHit = hit; lookupWay = lway; victimWay = vway; victimDirty = vdirty;
    victimAddress = vaddr; memFetchAck = 1'b0; memWriteBackAck = 1'b0;
    for (int k = 1; k <= len; k++) begin
      @(negedge clk);
      check_val($sformatf("%s_w%0d", name, k), obs(), ev[k]);
      check_val({name, "_req_overlap"}, memFetchReq & memWriteBackReq, 1'b0);
      if (cfa[k]) check_val({name, "_fetch_addr"}, fetchAddress, addr & 32'hFFFF_FFE0);
      if (cwa[k]) check_val({name, "_wb_addr"}, writeBackAddress, vaddr);
      memFetchAck     = fa[k];
      memWriteBackAck = wa[k];
      // The CPU may wiggle its request outside IDLE; it must be ignored.
      cpuRequest = (k < len) ? 1'($urandom_range(0, 1)) : 1'b0;
    end
  endtask

  function automatic int rand_wait();
    return ($urandom_range(0, 7) == 0) ? int'($urandom_range(14, 17)) : int'($urandom_range(0, 5));
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; cpuRequest = 1'b0; cpuRead = 1'b0; cpuWrite = 1'b0;
    cpuRequestAddress = 32'h0; lookupHit = 1'b0; lookupWay = 2'd0; victimWay = 2'd0;
    victimDirty = 1'b0; victimAddress = 32'h0; memFetchAck = 1'b0; memWriteBackAck = 1'b0;
    repeat (2) @(negedge clk);
    check_val("reset_vec", obs(), B_READY);
    check_val("reset_faddr", fetchAddress, 32'h0);
    check_val("reset_wbaddr", writeBackAddress, 32'h0);
    rst_n = 1'b1;

    run_txn("read_hit", 1'b1, 1'b0, 32'h0000_0040, 1'b1, 2'd2, 2'd0, 1'b0, 32'h0, 0, 0);
    run_txn("write_miss_clean", 1'b0, 1'b1, 32'h0000_1234, 1'b0, 2'd3, 2'd1, 1'b0, 32'h0, 0, 4);
    run_txn("read_miss_dirty", 1'b1, 1'b0, 32'h0000_2468, 1'b0, 2'd0, 2'd3, 1'b1, 32'h0000_8000, 3, 2);
    run_txn("fetch_timeout", 1'b1, 1'b0, 32'h0000_0100, 1'b0, 2'd0, 2'd2, 1'b0, 32'h0, 0, 40);
    run_txn("fetch_ack_at_limit", 1'b0, 1'b1, 32'h0000_0ABC, 1'b0, 2'd0, 2'd2, 1'b0, 32'h0, 0, 15);
    run_txn("wb_timeout", 1'b0, 1'b1, 32'h0000_0200, 1'b0, 2'd0, 2'd1, 1'b1, 32'h0000_4000, 16, 0);
    run_txn("illegal_both", 1'b1, 1'b1, 32'h0000_0300, 1'b1, 2'd1, 2'd0, 1'b0, 32'h0, 0, 0);
    run_txn("illegal_none", 1'b0, 1'b0, 32'h0000_0300, 1'b1, 2'd1, 2'd0, 1'b0, 32'h0, 0, 0);

    // Reset while a fetch is outstanding.
    @(negedge clk);
    cpuRequest = 1'b1; cpuRead = 1'b1; cpuWrite = 1'b0; cpuRequestAddress = 32'h0000_5550;
    lookupHit = 1'b0; victimDirty = 1'b0; memFetchAck = 1'b0; memWriteBackAck = 1'b0;
    @(negedge clk);
    cpuRequest = 1'b0;
    repeat (3) @(negedge clk);
    check_val("rst_pre_freq", memFetchReq, 1'b1);
    rst_n = 1'b0;
    #1;
    check_val("rst_freq_drop", memFetchReq, 1'b0);
    check_val("rst_vec", obs(), B_READY);
    @(negedge clk);
    rst_n = 1'b1;
    run_txn("hit_after_reset", 1'b1, 1'b0, 32'h0000_0080, 1'b1, 2'd1, 2'd0, 1'b0, 32'h0, 0, 0);

    for (int n = 0; n < 150; n++) begin
      int   r;
      logic rd;
      logic wr;
      r = int'($urandom_range(0, 15));
      if (r == 0) begin
        rd = 1'b1; wr = 1'b1;
      end else if (r == 1) begin
        rd = 1'b0; wr = 1'b0;
      end else begin
        rd = 1'($urandom_range(0, 1)); wr = ~rd;
      end
      run_txn($sformatf("rnd%0d", n), rd, wr, $urandom, 1'($urandom_range(0, 1)),
              2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
              $urandom & 32'hFFFF_FFE0, rand_wait(), rand_wait());
    end

    @(negedge clk);
    check_val("final_idle", obs(), B_READY);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
